// File: rtl/servant_ram_loader.sv
//------------------------------------------------------------------------------
// Module   : servant_ram_loader
// Brief    : Packs a little-endian byte stream into 32-bit Wishbone writes to the
//            servant RAM and holds the CPU in reset until the image is loaded.
//            Optional checksum stage enabled by SERVANT_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module servant_ram_loader #(
    parameter int depth      = 256,
    parameter int aw         = $clog2(depth),
    parameter int LOAD_WORDS = depth / 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic [29:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic        i_wb_ack,
    output logic        o_cpu_rst,
    output logic        o_done,
    output logic        o_err
);

    localparam int WW = $clog2(LOAD_WORDS + 1);
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(LOAD_WORDS - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT != 0);
`ifdef SERVANT_LOADER_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_WRITE   = 2'd1,
        S_DONE    = 2'd2,
        S_CKSUM   = 2'd3
    } state_t;

    state_t          state;
    logic [WW-1:0]   wcnt;
    logic [aw-3:0]   wadr;
    logic [1:0]      bidx;
    logic [31:0]     data;
    logic [31:0]     data_nxt;
    logic [3:0]      sel;
    logic [3:0]      sel_nxt;
    logic [IW-1:0]   idle;
    logic            seen;
    logic            tmo;
    logic            accept;
    logic            idle_hit;

    assign accept   = i_byte_valid & o_byte_ready;
    assign idle_hit = TMO_EN && seen && !accept && (idle == IDLE_LAST);
    assign wadr     = (aw-2)'(wcnt);

    always_comb begin
        data_nxt              = data;
        data_nxt[8*bidx +: 8] = i_byte;
        sel_nxt               = sel;
        sel_nxt[bidx]         = 1'b1;
    end

`ifdef SERVANT_LOADER_CHECKSUM_EN
    logic [7:0] sum;
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state        <= S_COLLECT;
            o_byte_ready <= 1'b0;
            o_wb_cyc     <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_sel     <= 4'd0;
            o_wb_adr     <= 30'd0;
            o_wb_dat     <= 32'd0;
            o_cpu_rst    <= 1'b1;
            o_done       <= 1'b0;
            wcnt         <= '0;
            bidx         <= 2'd0;
            data         <= 32'd0;
            sel          <= 4'd0;
            idle         <= '0;
            seen         <= 1'b0;
            tmo          <= 1'b0;
`ifdef SERVANT_LOADER_CHECKSUM_EN
            sum          <= 8'd0;
            o_err        <= 1'b0;
`endif
        end else begin
            case (state)
                S_COLLECT: begin
                    o_byte_ready <= 1'b1;
                    if (accept) begin
                        data <= data_nxt;
                        sel  <= sel_nxt;
                        bidx <= bidx + 2'd1;
                        seen <= 1'b1;
                        idle <= '0;
`ifdef SERVANT_LOADER_CHECKSUM_EN
                        sum  <= sum + i_byte;
`endif
                        if (bidx == 2'd3) begin
                            state        <= S_WRITE;
                            o_byte_ready <= 1'b0;
                            o_wb_cyc     <= 1'b1;
                            o_wb_we      <= 1'b1;
                            o_wb_adr     <= 30'(wadr);
                            o_wb_dat     <= data_nxt;
                            o_wb_sel     <= sel_nxt;
                        end
                    end else if (idle_hit) begin
                        if (bidx != 2'd0) begin
                            // Flush the partial word with only the received lanes enabled
                            state        <= S_WRITE;
                            tmo          <= 1'b1;
                            o_byte_ready <= 1'b0;
                            o_wb_cyc     <= 1'b1;
                            o_wb_we      <= 1'b1;
                            o_wb_adr     <= 30'(wadr);
                            o_wb_dat     <= data;
                            o_wb_sel     <= sel;
                        end else begin
                            state        <= CKS ? S_CKSUM : S_DONE;
                            o_byte_ready <= CKS;
                            o_done       <= !CKS;
                            o_cpu_rst    <= CKS;
                            idle         <= '0;
                        end
                    end else if (TMO_EN && seen) begin
                        idle <= idle + 1'b1;
                    end
                end

                S_WRITE: begin
                    if (i_wb_ack) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_we  <= 1'b0;
                        o_wb_sel <= 4'd0;
                        wcnt     <= wcnt + 1'b1;
                        bidx     <= 2'd0;
                        sel      <= 4'd0;
                        data     <= 32'd0;
                        if (wcnt == LAST_WORD || tmo) begin
                            state        <= CKS ? S_CKSUM : S_DONE;
                            o_byte_ready <= CKS;
                            o_done       <= !CKS;
                            o_cpu_rst    <= CKS;
                            idle         <= '0;
                        end else begin
                            state        <= S_COLLECT;
                            o_byte_ready <= 1'b1;
                        end
                    end
                end

`ifdef SERVANT_LOADER_CHECKSUM_EN
                S_CKSUM: begin
                    // A bad checksum or a missing one keeps the CPU parked in reset
                    if (accept || idle_hit) begin
                        state        <= S_DONE;
                        o_byte_ready <= 1'b0;
                        o_done       <= 1'b1;
                        o_err        <= !accept || (i_byte != sum);
                        o_cpu_rst    <= !accept || (i_byte != sum);
                    end else if (TMO_EN) begin
                        idle <= idle + 1'b1;
                    end
                end
`endif

                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_servant_ram_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_servant_ram_loader
// Brief    : Scoreboard bench for servant_ram_loader with a Wishbone RAM model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_servant_ram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_byte = 8'd0;
    logic        in_valid = 1'b0;
    logic        byte_ready;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;
    logic        cpu_rst;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    servant_ram_loader #(
        .depth(256), .LOAD_WORDS(2), .TIMEOUT(16)
    ) dut (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_byte(in_byte), .i_byte_valid(in_valid),
        .o_byte_ready(byte_ready), .o_wb_adr(wb_adr), .o_wb_dat(wb_dat),
        .o_wb_sel(wb_sel), .o_wb_we(wb_we), .o_wb_cyc(wb_cyc), .i_wb_ack(wb_ack),
        .o_cpu_rst(cpu_rst), .o_done(done), .o_err(err)
    );

    typedef struct packed {
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    wr_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ack_delay = 1;
    bit         rand_ack  = 1'b0;
    logic [7:0] run_sum   = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM model: word memory, byte lanes, programmable ack latency
    logic [31:0] mem [0:63];
    bit          mem_init = 1'b0;
    int          cnt = 0;
    int          rdly = 1;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE0000 | i;
            mem_init <= 1'b1;
        end
        if (rst) begin
            wb_ack <= 1'b0;
            cnt    <= 0;
        end else if (wb_cyc && !wb_ack) begin
            if (cnt + 1 >= (rand_ack ? rdly : ack_delay)) begin
                wb_ack <= 1'b1;
                cnt    <= 0;
                rdly   <= $urandom_range(1, 5);
                for (int b = 0; b < 4; b++)
                    if (wb_sel[b]) mem[wb_adr[5:0]][8*b +: 8] <= wb_dat[8*b +: 8];
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            wb_ack <= 1'b0;
        end
    end

    // Monitor: bus stability, no byte handshake during a cycle, scoreboard pop on ack
    initial begin
        logic        p_cyc = 1'b0;
        logic        p_ack = 1'b0;
        logic [65:0] p_bus = '0;
        wr_t         e;
        forever begin
            @(negedge clk);
            if (!rst && wb_cyc) begin
                check("we_eq_cyc", wb_we, 1'b1);
                check("ready_in_write", byte_ready, 1'b0);
                if (p_cyc && !p_ack)
                    check("bus_stable", {wb_adr, wb_dat, wb_sel}, p_bus[65:0] & 66'h3_FFFF_FFFF);
                if (wb_ack) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: adr %h dat %h sel %h", wb_adr, wb_dat, wb_sel);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_adr", 32'(wb_adr), 32'(e.adr));
                        check("wr_dat", wb_dat, e.dat);
                        check("wr_sel", 32'(wb_sel), 32'(e.sel));
                    end
                end
            end
            p_cyc = wb_cyc && !rst;
            p_ack = wb_ack;
            p_bus = {wb_adr, wb_dat, wb_sel};
        end
    end

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        in_byte  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte %h not accepted", b);
        end else begin
            @(posedge clk);
            #1;
            run_sum = run_sum + b;
        end
    endtask

    task automatic send_word(input int adr, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        wr_t e;
        e.adr = 30'(adr);
        e.dat = {b3, b2, b1, b0};
        e.sel = 4'hF;
        exp_q.push_back(e);
        send(b0); send(b1); send(b2); send(b3);
    endtask

    task automatic wait_bus_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !wb_cyc) begin
                ok = 1'b1;
                break;
            end
        end
        check("writes_drained", 32'(ok), 32'd1);
    endtask

    // Final write must already be complete; the checksum stage follows immediately
    task automatic close_load();
        wait_bus_idle();
`ifdef SERVANT_LOADER_CHECKSUM_EN
        begin
            logic [7:0] s;
            s = run_sum;
            send(s);
            in_valid = 1'b0;
        end
`endif
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_reached", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        run_sum  = 8'd0;
    endtask

    task automatic wait_cyc();
        bit ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (wb_cyc) begin
                ok = 1'b1;
                break;
            end
        end
        check("cyc_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", byte_ready, 1'b0);
        check("rst_cyc", wb_cyc, 1'b0);
        check("rst_we", wb_we, 1'b0);
        check("rst_sel", 32'(wb_sel), 32'd0);
        check("rst_adr", 32'(wb_adr), 32'd0);
        check("rst_dat", wb_dat, 32'd0);
        check("rst_cpu_rst", cpu_rst, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;

        // Two full words, one-cycle ack
        ack_delay = 1;
        send_word(0, 8'h37, 8'h05, 8'h00, 8'h40);
        send_word(1, 8'h13, 8'h05, 8'h05, 8'h00);
        in_valid = 1'b0;
        close_load();
        wait_done();
        check("t1_cpu_rst", cpu_rst, 1'b0);
        check("t1_ready", byte_ready, 1'b0);
        check("t1_err", err, 1'b0);
        check("t1_mem0", mem[0], 32'h40000537);
        check("t1_mem1", mem[1], 32'h00050513);

        // Bytes offered after completion are never taken
        in_byte  = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("done_ignores_bytes", byte_ready, 1'b0);
        end
        in_valid = 1'b0;

        // Timeout with a partial word
        do_reset();
        begin
            wr_t e;
            e.adr = 30'd0; e.dat = 32'h0000BBAA; e.sel = 4'h3;
            exp_q.push_back(e);
        end
        send(8'hAA);
        send(8'hBB);
        in_valid = 1'b0;
        close_load();
        wait_done();
        check("t3_cpu_rst", cpu_rst, 1'b0);
        check("t3_mem0", mem[0], 32'h4000BBAA);
        check("t3_mem1", mem[1], 32'h00050513);
        check("t3_mem2", mem[2], 32'hC0DE0002);

        // Reset in the middle of a bus cycle
        do_reset();
        ack_delay = 5;
        send(8'h99); send(8'h98); send(8'h97); send(8'h96);
        in_valid = 1'b0;
        wait_cyc();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t4_cyc", wb_cyc, 1'b0);
        check("t4_cpu_rst", cpu_rst, 1'b1);
        check("t4_done", done, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        run_sum   = 8'd0;
        ack_delay = 1;
        send_word(0, 8'h11, 8'h22, 8'h33, 8'h44);
        send_word(1, 8'h55, 8'h66, 8'h77, 8'h88);
        in_valid = 1'b0;
        close_load();
        wait_done();
        check("t4_mem0", mem[0], 32'h44332211);
        check("t4_mem1", mem[1], 32'h88776655);

        // Valid held high, random ack latency
        do_reset();
        rand_ack = 1'b1;
        send_word(0, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
        send_word(1, 8'h01, 8'h23, 8'h45, 8'h67);
        in_valid = 1'b0;
        close_load();
        wait_done();
        rand_ack = 1'b0;
        check("t5_mem0", mem[0], 32'hEFBEADDE);
        check("t5_mem1", mem[1], 32'h67452301);
        check("t5_cpu_rst", cpu_rst, 1'b0);

`ifdef SERVANT_LOADER_CHECKSUM_EN
        // One word then timeout into the checksum stage: good and bad checksum
        do_reset();
        send_word(0, 8'h01, 8'h02, 8'h03, 8'h04);
        in_valid = 1'b0;
        wait_bus_idle();
        repeat (20) @(negedge clk);
        send(8'h0A);
        in_valid = 1'b0;
        wait_done();
        check("ck_ok_err", err, 1'b0);
        check("ck_ok_cpu_rst", cpu_rst, 1'b0);

        do_reset();
        send_word(0, 8'h01, 8'h02, 8'h03, 8'h04);
        in_valid = 1'b0;
        wait_bus_idle();
        repeat (20) @(negedge clk);
        send(8'h0B);
        in_valid = 1'b0;
        wait_done();
        check("ck_bad_err", err, 1'b1);
        check("ck_bad_cpu_rst", cpu_rst, 1'b1);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/servant_ram_loader.md
Name: servant_ram_loader

Overview:
- Byte-stream boot loader sitting directly upstream of the servant Wishbone RAM.
- Accepts a little-endian byte stream (from a UART RX or a debug FIFO) and assembles it into 32-bit words.
- Issues Wishbone word writes to the RAM at auto-incrementing addresses.
- Holds the CPU in reset until loading completes, then releases it and disconnects from the bus.

Parameters:
- depth, 256, RAM size in bytes; must match the RAM instance.
- aw, $clog2(depth), byte-address width.
- LOAD_WORDS, depth/4, number of words written before normal completion; 1..depth/4.
- TIMEOUT, 1000000, idle cycles after the first byte that force early completion; 0 disables the timeout.

Ports:
- i_wb_clk  in  1  clock; all logic on its rising edge.
- i_wb_rst  in  1  synchronous, active-high reset.
- i_byte  in  8  stream data byte.
- i_byte_valid  in  1  i_byte is valid this cycle.
- o_byte_ready  out  1  loader accepts a byte this cycle; transfer occurs when valid & ready.
- o_wb_adr  out  30  word address [31:2]; bits above aw-1 are zero.
- o_wb_dat  out  32  write data.
- o_wb_sel  out  4  byte enables.
- o_wb_we  out  1  write enable; equals o_wb_cyc.
- o_wb_cyc  out  1  bus cycle request.
- i_wb_ack  in  1  RAM acknowledge.
- o_cpu_rst  out  1  CPU reset; high while loading.
- o_done  out  1  load complete; sticky until reset.
- o_err  out  1  checksum error; only with CHECKSUM_EN, tied 0 otherwise.

Behaviour:
- Reset values: o_byte_ready=0, o_wb_cyc=0, o_wb_we=0, o_wb_sel=0, o_wb_adr=0, o_wb_dat=0, o_cpu_rst=1, o_done=0, o_err=0.
- Internal state: word counter wcnt (0..LOAD_WORDS), byte index bidx (2 bits), data shift register, sel accumulator, idle counter, seen flag.
- State COLLECT:
  - o_byte_ready=1.
  - On each accepted byte: data[8*bidx+:8]=i_byte, sel[bidx]=1, bidx++, seen=1, idle counter cleared.
  - Fourth byte (bidx==3) -> WRITE.
- State WRITE:
  - o_byte_ready=0; o_wb_cyc=o_wb_we=1; o_wb_adr=wcnt; o_wb_dat/o_wb_sel from the accumulators.
  - Signals are held stable until i_wb_ack.
  - On the ack edge: cyc/we/sel drop the next cycle, wcnt++, bidx and sel cleared.
  - Next state: DONE if wcnt+1==LOAD_WORDS or the write was timeout-triggered; otherwise COLLECT.
  - With the RAM's one-cycle ack, a word costs 4 byte cycles + 2 bus cycles.
  - Re-writing the same data during the ack cycle is permitted.
- Timeout:
  - In COLLECT with seen=1 and TIMEOUT!=0, the idle counter increments every cycle without an accepted byte.
  - Reaching TIMEOUT with bidx!=0: write the partial word with sel = received bytes only, then go to DONE.
  - Reaching TIMEOUT with bidx==0: go directly to DONE.
  - No timeout before the first byte (seen=0).
- State DONE:
  - o_byte_ready=0, o_wb_cyc=0, o_cpu_rst=0, o_done=1.
  - Further input bytes are ignored (never accepted). Only reset leaves DONE.
- Simultaneous events: a valid byte is never accepted in the same cycle as cyc=1. The timeout cannot fire in WRITE.
- Reset mid-operation: applies immediately at the next edge even while cyc=1. The bus cycle is abandoned; wcnt, bidx and seen are cleared.
- Address wrap: wcnt never exceeds LOAD_WORDS-1 on the bus, so there is no wrap.

Optional Feature:
- Macro SERVANT_LOADER_CHECKSUM_EN.
- Defined:
  - After LOAD_WORDS words (or after a timeout), the state CKSUM accepts one more byte with o_byte_ready=1.
  - The running 8-bit sum of all data bytes, mod 256, is compared with it.
  - Match: DONE, o_err=0.
  - Mismatch: DONE with o_err=1, o_done=1, but o_cpu_rst stays 1.
  - A timeout while in CKSUM counts as a mismatch.
- Undefined: no CKSUM state; o_err is constant 0.

Test Plan:
- Reset, then stream 0x37,0x05,0x00,0x40 with LOAD_WORDS=2 -> one write: adr=0, dat=0x40000537, sel=0xF, cyc held until ack; o_byte_ready=0 during the write.
- Second word 0x13,0x05,0x05,0x00 -> write at adr=1, dat=0x00050513; next cycle o_done=1, o_cpu_rst=0, o_byte_ready=0; RAM readback of words 0/1 matches.
- TIMEOUT=16: send 2 bytes 0xAA,0xBB, then idle 16 cycles -> write adr=0, dat=0x0000BBAA, sel=0x3, then DONE; other RAM bytes unchanged.
- Assert i_wb_rst while cyc=1 (before ack) -> next edge: cyc=0, o_cpu_rst=1, o_done=0; a resend loads again from adr=0.
- Valid held high continuously with random ack delay 1-5 cycles -> no byte lost or duplicated; 4 bytes accepted per word; stable bus signals until ack.
- CHECKSUM_EN, one word 0x01,0x02,0x03,0x04: checksum byte 0x0A -> o_done=1, o_err=0, o_cpu_rst=0. Checksum 0x0B -> o_err=1, o_cpu_rst=1.
